// File: rtl/mb_spi_frame_slave_if.sv
// ---------------------------------------------------------------------------
// mb_spi_frame_slave_if
// Pin bundle for the MB MCU SPI link.
//   CLK  : SPI clock, driven by the MCU (asynchronous to the FPGA clock)
//   MOSI : data from the MCU
//   MISO : data to the MCU
//   LOAD : frame select, active low, driven by the MCU
// The MCU side uses the master modport; the FPGA frame slave uses slave.
// ---------------------------------------------------------------------------
interface mb_spi_frame_slave_if;
    logic CLK;
    logic MOSI;
    logic MISO;
    logic LOAD;

    modport master (output CLK, output MOSI, output LOAD, input MISO);
    modport slave  (input CLK, input MOSI, input LOAD, output MISO);
endinterface

// File: rtl/mb_spi_frame_slave.sv
// ---------------------------------------------------------------------------
// mb_spi_frame_slave
// Slave end of the FPGA <-> MB MCU SPI link. Each LOAD-low window is one
// full-duplex frame: a snapshot of tx_data is shifted out MSB first on MISO
// while NUM_AIN analog words and CTRL_BITS control bits are shifted in on
// MOSI. Only frames of exactly FRAME_BITS sample edges update the outputs;
// any other length raises frame_err and bumps a saturating error counter.
//
// Ports
//   clock     : system clock, all logic on its rising edge
//   reset     : synchronous, active-high
//   tx_data   : frame to send, sampled on the LOAD falling edge
//   ain_out   : analog words, channel k at [k*AIN_WIDTH +: AIN_WIDTH]
//   ctrl_out  : control bits from the last good frame
//   rx_valid  : 1-cycle pulse when ain_out/ctrl_out update
//   frame_err : 1-cycle pulse when a frame is rejected
//   err_count : saturating count of rejected frames
//   busy      : high while a frame is being shifted
//   spi       : SPI pins (CLK, MOSI, LOAD in; MISO out), slave side
// ---------------------------------------------------------------------------
module mb_spi_frame_slave #(
    parameter int                  NUM_AIN    = 6,
    parameter int                  AIN_WIDTH  = 12,
    parameter int                  CTRL_BITS  = 8,
    parameter logic [CTRL_BITS-1:0] CTRL_RESET = CTRL_BITS'(8'h06),
    parameter bit                  CPOL       = 1'b0,
    localparam int                 AIN_BITS   = NUM_AIN * AIN_WIDTH,
    localparam int                 FRAME_BITS = AIN_BITS + CTRL_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [AIN_BITS-1:0]   ain_out,
    output logic [CTRL_BITS-1:0]  ctrl_out,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic                  busy,
    mb_spi_frame_slave_if.slave   spi
);

    // Bit counter saturates one past a full frame so over-long frames
    // stay distinguishable from exact ones.
    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // ------------------------------------------------------------------
    // Pin synchronisers. Bits [1:0] are the two-flop synchroniser, bit [2]
    // holds the previous synchronised value for edge detection. CLK is
    // XORed with CPOL first so a rising edge is always the sample edge.
    // ------------------------------------------------------------------
    logic [2:0] sck_sync_q;
    logic [2:0] load_sync_q;
    logic [1:0] mosi_sync_q;

    // NOTE: the synchronisers are deliberately not reset: they keep tracking
    // the pins during reset, so a LOAD that is already low at reset release
    // shows no falling edge and cannot start a spurious frame.
    always_ff @(posedge clock) begin
        sck_sync_q  <= {sck_sync_q[1:0], spi.CLK ^ CPOL};
        load_sync_q <= {load_sync_q[1:0], spi.LOAD};
        mosi_sync_q <= {mosi_sync_q[0], spi.MOSI};
    end

    logic sck_rise;
    logic sck_fall;
    logic load_rise;
    logic load_fall;

    assign sck_rise  =  sck_sync_q[1]  & ~sck_sync_q[2];
    assign sck_fall  = ~sck_sync_q[1]  &  sck_sync_q[2];
    assign load_rise =  load_sync_q[1] & ~load_sync_q[2];
    assign load_fall = ~load_sync_q[1] &  load_sync_q[2];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0]            state_q,     state_d;
    logic [FRAME_BITS-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0]      bitcnt_q,    bitcnt_d;
    logic                  miso_q,      miso_d;
    logic [AIN_BITS-1:0]   ain_q,       ain_d;
    logic [CTRL_BITS-1:0]  ctrl_q,      ctrl_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            err_count_q, err_count_d;

    // NOTE: every signal gets its hold value before the case statement, so
    // no path through the block leaves one unassigned and no latch is built.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        miso_d      = miso_q;
        ain_d       = ain_q;
        ctrl_d      = ctrl_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (load_fall) begin
                    shreg_d  = tx_data;
                    miso_d   = tx_data[FRAME_BITS-1];
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // LOAD release wins over an SCK edge seen in the same cycle.
                if (load_rise) begin
                    state_d = ST_COMMIT;
                end else if (sck_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_sync_q[1]};
                    if (bitcnt_q != CNT_MAX) begin
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    miso_d = shreg_q[FRAME_BITS-1];
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (bitcnt_q == CNT_FULL) begin
                    ain_d      = shreg_q[AIN_BITS-1:0];
                    ctrl_d     = shreg_q[FRAME_BITS-1 -: CTRL_BITS];
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            miso_q      <= 1'b0;
            ain_q       <= '0;
            ctrl_q      <= CTRL_RESET;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            miso_q      <= miso_d;
            ain_q       <= ain_d;
            ctrl_q      <= ctrl_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign ain_out   = ain_q;
    assign ctrl_out  = ctrl_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign busy      = (state_q == ST_SHIFT);
    assign spi.MISO  = miso_q;

endmodule

// File: tb/tb_mb_spi_frame_slave.sv
// ---------------------------------------------------------------------------
// tb_mb_spi_frame_slave
// Directed bench for mb_spi_frame_slave. Instance 0 uses the default
// parameters (80-bit frame, CPOL=0); instance 1 uses CPOL=1 with a 24-bit
// frame (2 x 10-bit words + 4 control bits). The bench plays the MCU.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mb_spi_frame_slave;

    localparam int HALF = 6;    // SCK half-period in system clocks

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Logical pin levels per instance; instance 1 sees an inverted SCK.
    logic [1:0] sck_l;
    logic [1:0] mosi_v;
    logic [1:0] load_v;

    mb_spi_frame_slave_if spi0();
    mb_spi_frame_slave_if spi1();

    assign spi0.CLK  = sck_l[0];
    assign spi0.MOSI = mosi_v[0];
    assign spi0.LOAD = load_v[0];
    assign spi1.CLK  = ~sck_l[1];
    assign spi1.MOSI = mosi_v[1];
    assign spi1.LOAD = load_v[1];

    // Instance 0: defaults
    logic [79:0] tx0;
    logic [71:0] ain0;
    logic [7:0]  ctrl0;
    logic        rx0, ferr0, busy0;
    logic [7:0]  errc0;

    mb_spi_frame_slave u_dut0 (
        .clock     (clk),
        .reset     (rst),
        .tx_data   (tx0),
        .ain_out   (ain0),
        .ctrl_out  (ctrl0),
        .rx_valid  (rx0),
        .frame_err (ferr0),
        .err_count (errc0),
        .busy      (busy0),
        .spi       (spi0)
    );

    // Instance 1: CPOL=1, 24-bit frame
    logic [23:0] tx1;
    logic [19:0] ain1;
    logic [3:0]  ctrl1;
    logic        rx1, ferr1, busy1;
    logic [7:0]  errc1;

    mb_spi_frame_slave #(
        .NUM_AIN    (2),
        .AIN_WIDTH  (10),
        .CTRL_BITS  (4),
        .CTRL_RESET (4'h6),
        .CPOL       (1'b1)
    ) u_dut1 (
        .clock     (clk),
        .reset     (rst),
        .tx_data   (tx1),
        .ain_out   (ain1),
        .ctrl_out  (ctrl1),
        .rx_valid  (rx1),
        .frame_err (ferr1),
        .err_count (errc1),
        .busy      (busy1),
        .spi       (spi1)
    );

    // Pulse counters, sampled mid-cycle
    int rx0_n  = 0;
    int err0_n = 0;
    int rx1_n  = 0;
    int err1_n = 0;
    always @(negedge clk) begin
        if (rx0)   rx0_n++;
        if (ferr0) err0_n++;
        if (rx1)   rx1_n++;
        if (ferr1) err1_n++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [127:0] miso_cap;

    task automatic spi_start(input int w);
        miso_cap  = '0;
        load_v[w] = 1'b0;
        wait_clk(HALF);
    endtask

    // Shifts nbits of data MSB first (data[nbits-1] first). MISO is captured
    // just before each sample edge. With coincide set, LOAD rises together
    // with the last sample edge.
    task automatic spi_shift(input int w, input logic [127:0] data, input int nbits, input bit coincide);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi_v[w] = data[i];
            wait_clk(HALF);
            miso_cap = {miso_cap[126:0], (w == 0) ? spi0.MISO : spi1.MISO};
            sck_l[w] = 1'b1;
            if (coincide && i == 0) load_v[w] = 1'b1;
            wait_clk(HALF);
            sck_l[w] = 1'b0;
        end
    endtask

    task automatic spi_stop(input int w);
        wait_clk(HALF);
        load_v[w] = 1'b1;
        wait_clk(10);
    endtask

    int rx_s, err_s;
    logic [79:0] frame;

    initial begin
        rst    = 1'b1;
        sck_l  = 2'b00;
        mosi_v = 2'b00;
        load_v = 2'b11;
        tx0    = 80'h0123_4567_89AB_CDEF_F00D;
        tx1    = {4'hC, 10'h2AA, 10'h155};
        wait_clk(5);
        rst = 1'b0;
        wait_clk(3);

        // Reset state
        check("rst_ain0",  128'(ain0),  128'h0);
        check("rst_ctrl0", 128'(ctrl0), 128'h06);
        check("rst_errc0", 128'(errc0), 128'h0);
        check("rst_busy0", 128'(busy0), 128'h0);
        check("rst_miso0", 128'(spi0.MISO), 128'h0);
        check("rst_ctrl1", 128'(ctrl1), 128'h6);

        // 1: full 80-bit frame
        rx_s  = rx0_n;
        frame = {8'hA5, 72'h666_555_444_333_222_111};
        spi_start(0);
        check("t1_busy", 128'(busy0), 128'h1);
        spi_shift(0, 128'(frame), 80, 1'b0);
        tx0 = 80'hFFFF_0000_FFFF_0000_FFFF;   // change after snapshot, not seen
        spi_stop(0);
        check("t1_ctrl",  128'(ctrl0), 128'hA5);
        check("t1_ain",   128'(ain0),  128'h666555444333222111);
        check("t1_ch0",   128'(ain0[11:0]),  128'h111);
        check("t1_ch5",   128'(ain0[71:60]), 128'h666);
        check("t1_rx",    128'(rx0_n - rx_s), 128'd1);
        check("t1_miso",  128'(miso_cap[79:0]), 128'h0123_4567_89AB_CDEF_F00D);
        check("t1_busy_end", 128'(busy0), 128'h0);

        // 2: 79-bit then 81-bit frame
        rx_s  = rx0_n;
        err_s = err0_n;
        spi_start(0);
        spi_shift(0, 128'h5A5A_5A5A_5A5A_5A5A_5A5A, 79, 1'b0);
        spi_stop(0);
        spi_start(0);
        spi_shift(0, 128'h1_3C3C_3C3C_3C3C_3C3C_3C3C, 81, 1'b0);
        spi_stop(0);
        check("t2_err_pulses", 128'(err0_n - err_s), 128'd2);
        check("t2_errc",  128'(errc0), 128'd2);
        check("t2_rx",    128'(rx0_n - rx_s), 128'd0);
        check("t2_ctrl",  128'(ctrl0), 128'hA5);
        check("t2_ain",   128'(ain0),  128'h666555444333222111);

        // 3: CPOL=1 instance, 24-bit frame
        spi_start(1);
        spi_shift(1, 128'({4'h9, 10'h3FF, 10'h001}), 24, 1'b0);
        spi_stop(1);
        check("t3_ctrl", 128'(ctrl1), 128'h9);
        check("t3_ch1",  128'(ain1[19:10]), 128'h3FF);
        check("t3_ch0",  128'(ain1[9:0]),   128'h001);
        check("t3_rx",   128'(rx1_n), 128'd1);
        check("t3_err",  128'(err1_n), 128'd0);
        check("t3_miso", 128'(miso_cap[23:0]), 128'({4'hC, 10'h2AA, 10'h155}));

        // 4: reset mid-frame, release with LOAD low, finish the frame
        tx0   = 80'h0123_4567_89AB_CDEF_F00D;
        rx_s  = rx0_n;
        err_s = err0_n;
        frame = {8'h3C, 72'hABC_DEF_012_345_678_9AB};
        spi_start(0);
        spi_shift(0, 128'(frame[79:40]), 40, 1'b0);
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        check("t4_rst_ain",  128'(ain0),  128'h0);
        check("t4_rst_ctrl", 128'(ctrl0), 128'h06);
        check("t4_rst_errc", 128'(errc0), 128'h0);
        spi_shift(0, 128'(frame[39:0]), 40, 1'b0);
        spi_stop(0);
        check("t4_rx",   128'(rx0_n - rx_s), 128'd0);
        check("t4_err",  128'(err0_n - err_s), 128'd0);
        check("t4_ain",  128'(ain0),  128'h0);
        check("t4_ctrl", 128'(ctrl0), 128'h06);
        check("t4_errc", 128'(errc0), 128'h0);
        spi_start(0);
        spi_shift(0, 128'(frame), 80, 1'b0);
        spi_stop(0);
        check("t4_next_rx",   128'(rx0_n - rx_s), 128'd1);
        check("t4_next_ctrl", 128'(ctrl0), 128'h3C);
        check("t4_next_ain",  128'(ain0),  128'hABCDEF0123456789AB);

        // 6: LOAD rise coincident with the 81st sample edge
        rx_s  = rx0_n;
        err_s = err0_n;
        spi_start(0);
        spi_shift(0, {47'h0, 80'hC3_123_456_789_ABC_DEF_321, 1'b1}, 81, 1'b1);
        spi_stop(0);
        check("t6_rx",   128'(rx0_n - rx_s), 128'd1);
        check("t6_err",  128'(err0_n - err_s), 128'd0);
        check("t6_ctrl", 128'(ctrl0), 128'hC3);
        check("t6_ain",  128'(ain0),  128'h123456789ABCDEF321);

        // 5: 300 empty frames saturate the error counter
        err_s = err0_n;
        for (int k = 0; k < 300; k++) begin
            spi_start(0);
            spi_stop(0);
        end
        check("t5_err_pulses", 128'(err0_n - err_s), 128'd300);
        check("t5_errc", 128'(errc0), 128'hFF);
        rx_s = rx0_n;
        spi_start(0);
        spi_shift(0, 128'({8'h5A, 72'h111_222_333_444_555_666}), 80, 1'b0);
        spi_stop(0);
        check("t5_rx",   128'(rx0_n - rx_s), 128'd1);
        check("t5_ctrl", 128'(ctrl0), 128'h5A);
        check("t5_errc_hold", 128'(errc0), 128'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
